data_mem_initiator: RTL and testbench
=====================================

Name: data_mem_initiator

Overview:
- Pipeline-side master for the data memory port: the initiator end of the memread/memwrite/sign_mask/clk_stall interface.
- Accepts one load or store from the MEM stage via a valid/ready handshake and decodes funct3 into the memory's sign_mask encoding.
- Sequences the memory's one-cycle read latency and its write stall.
- Returns load data or an error flag; misaligned or illegal requests never reach memory.

Parameters:
- STALL_TIMEOUT, 8: max cycles in WRITE_WAIT without seeing the clk_stall high→low sequence before flagging an error.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (low bits used for SB/SH).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  with resp_valid: misaligned, illegal funct3 or stall timeout.
- mem_addr  out  32  to memory addr.
- mem_write_data  out  32  to memory write_data.
- mem_memread  out  1  to memory memread.
- mem_memwrite  out  1  to memory memwrite.
- mem_sign_mask  out  4  to memory sign_mask.
- mem_read_data  in  32  from memory read_data.
- mem_clk_stall  in  1  from memory clk_stall.

Behaviour:
- All outputs are registered. Reset value of every output is 0 except req_ready=1; state goes to IDLE and the timeout counter clears. Reset mid-operation abandons the request with no resp_valid, and mem_memread/mem_memwrite drop immediately.
- sign_mask encoding:
  - bit3 = sign-extend; bits[2:0] = 001 byte, 011 half, 111 word.
  - Loads: LB 000→1001, LH 001→1011, LW 010→0111, LBU 100→0001, LHU 101→0011.
  - Stores: SB 000→0001, SH 001→0011, SW 010→0111.
  - Any other funct3, including any store funct3 ≥ 011, is illegal.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches the request.
    - Illegal or misaligned request → ERROR. No mem strobe ever asserts.
    - Otherwise drive mem_addr, mem_sign_mask and mem_write_data, pulse the strobe → ACCESS.
  - ACCESS (1 cycle): exactly one of mem_memread/mem_memwrite is high; memory samples at the end of this cycle. Next: load → CAPTURE; store → WRITE_WAIT. Strobes clear on exit.
  - CAPTURE (1 cycle): register mem_read_data into resp_rdata, pulse resp_valid with resp_err=0 → IDLE. Load latency is 3 cycles from handshake edge to resp_valid.
  - WRITE_WAIT: hold mem_addr, mem_sign_mask and mem_write_data stable.
    - Track seen_stall. Once mem_clk_stall=1 has been seen and then mem_clk_stall=0 → resp_valid, resp_err=0 → IDLE.
    - A counter increments each cycle. On reaching STALL_TIMEOUT → ERROR.
  - ERROR (1 cycle): resp_valid=1, resp_err=1, resp_rdata=0 → IDLE.
- Only one request is outstanding. req_ready is low from the handshake cycle until the cycle after resp_valid.
- mem_memwrite must never be high in the cycle in which memory returns to its idle state; this prevents double writes.
- Address 0x2000 (LED register) gets no special treatment and passes through like any other address.
- resp_rdata holds its value until the next response.

Decomposition:
- Shared package `dmem_pkg`:
  - sign_mask localparams: SM_BYTE, SM_HALF, SM_WORD, SM_SIGNED.
  - funct3 constants.
  - state encoding.
- One natural sub-module: `dmem_req_decode`, combinational. Maps funct3, write and addr[1:0] to sign_mask, illegal and misaligned. It is reused by the exception logic.

Test Plan:
- LB from 0x0000_0103, memory returns 0x0000_0080 → mem_sign_mask=1001 during ACCESS; resp_valid 3 cycles after handshake with resp_rdata=0x0000_0080; req_ready low for the whole transaction.
- SW 0xDEADBEEF to 0x10, memory model stalls 1 cycle → mem_memwrite high exactly 1 cycle, mem_sign_mask=0111; mem_addr and mem_write_data stable through the stall; resp_valid after stall falls; a following read of 0x10 returns 0xDEADBEEF.
- LH at 0x11 → resp_valid with resp_err=1 the cycle after ERROR entry; mem_memread never asserted.
- Store with funct3=011 → resp_err=1; no mem strobes.
- SW while the memory model never raises clk_stall, STALL_TIMEOUT=8 → resp_err=1 after 8 WRITE_WAIT cycles; unit returns to IDLE with req_ready=1.
- reset asserted asynchronously during WRITE_WAIT → all mem strobes drop before the next clk edge; no resp_valid; the next LW 0x20 completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory initiator: sign_mask fields,
// RV32I load/store funct3 codes and the initiator state encoding.
package dmem_pkg;

  // sign_mask size field (bits [2:0]) and sign-extend flag (bit 3)
  localparam logic [2:0] SM_BYTE   = 3'b001;
  localparam logic [2:0] SM_HALF   = 3'b011;
  localparam logic [2:0] SM_WORD   = 3'b111;
  localparam logic [3:0] SM_SIGNED = 4'b1000;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Initiator FSM state encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ACCESS     = 3'd1;
  localparam logic [2:0] ST_CAPTURE    = 3'd2;
  localparam logic [2:0] ST_WRITE_WAIT = 3'd3;
  localparam logic [2:0] ST_ERROR      = 3'd4;

endpackage

// File: rtl/dmem_req_decode.sv
// Combinational request decode: funct3 + direction + low address bits
// into the memory sign_mask, plus illegal/misaligned flags.
module dmem_req_decode
  import dmem_pkg::*;
(
  input  logic       i_write,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_sign_mask,
  output logic       o_illegal,
  output logic       o_misaligned
);

  // Decode size/sign; unsigned forms exist only for loads.
  always_comb begin
    o_sign_mask  = 4'b0000;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_sign_mask = i_write ? {1'b0, SM_BYTE} : (SM_SIGNED | {1'b0, SM_BYTE});
      end
      F3_H: begin
        o_sign_mask  = i_write ? {1'b0, SM_HALF} : (SM_SIGNED | {1'b0, SM_HALF});
        o_misaligned = i_addr_lo[0];
      end
      F3_W: begin
        o_sign_mask  = {1'b0, SM_WORD};
        o_misaligned = |i_addr_lo;
      end
      F3_BU: begin
        if (i_write) o_illegal = 1'b1;
        else         o_sign_mask = {1'b0, SM_BYTE};
      end
      F3_HU: begin
        if (i_write) begin
          o_illegal = 1'b1;
        end else begin
          o_sign_mask  = {1'b0, SM_HALF};
          o_misaligned = i_addr_lo[0];
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_initiator.sv
// Pipeline-side master for the data memory port. Takes one load/store at a
// time over valid/ready, sequences the memory's one-cycle read latency and
// its clk_stall write handshake, and returns data or an error flag.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready is only ever high in IDLE, and the
// requester must hold req_* stable while req_valid is high and req_ready low.
// resp_valid is a single-cycle pulse with no back-pressure.
module data_mem_initiator
  import dmem_pkg::*;
#(
  parameter int STALL_TIMEOUT = 8,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_clk_stall,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen_stall;
  logic             r_is_write;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_write_data;
  logic             r_mem_memread;
  logic             r_mem_memwrite;
  logic [3:0]       r_mem_sign_mask;

  logic       w_hs;
  logic [3:0] w_sign_mask;
  logic       w_illegal;
  logic       w_misaligned;

  assign w_hs = req_valid & r_req_ready;

  dmem_req_decode u_decode (
    .i_write      (req_write),
    .i_funct3     (req_funct3),
    .i_addr_lo    (req_addr[1:0]),
    .o_sign_mask  (w_sign_mask),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned)
  );

  // FSM plus all registered outputs; strobes and resp pulses default low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_seen_stall     <= 1'b0;
      r_is_write       <= 1'b0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= 32'h0;
      r_resp_err       <= 1'b0;
      r_mem_addr       <= 32'h0;
      r_mem_write_data <= 32'h0;
      r_mem_memread    <= 1'b0;
      r_mem_memwrite   <= 1'b0;
      r_mem_sign_mask  <= 4'b0000;
    end else begin
      r_resp_valid   <= 1'b0;
      r_resp_err     <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // ready comes back one cycle after the response pulse
          r_req_ready <= ~w_hs;
          if (w_hs) begin
            r_is_write <= req_write;
            if (w_illegal || w_misaligned) begin
              r_state <= ST_ERROR;
            end else begin
              r_mem_addr       <= 32'(req_addr);
              r_mem_sign_mask  <= w_sign_mask;
              r_mem_write_data <= req_wdata;
              r_mem_memwrite   <= req_write;
              r_mem_memread    <= ~req_write;
              r_state          <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt        <= '0;
          r_seen_stall <= 1'b0;
          r_state      <= r_is_write ? ST_WRITE_WAIT : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= mem_read_data;
          r_state      <= ST_IDLE;
        end
        ST_WRITE_WAIT: begin
          // write completes on the stall falling edge after it was seen high
          if (mem_clk_stall) r_seen_stall <= 1'b1;
          if (r_seen_stall && !mem_clk_stall) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'h0;
            r_state      <= ST_IDLE;
          end else if (r_cnt == CNT_W'(STALL_TIMEOUT - 1)) begin
            r_state <= ST_ERROR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ERROR: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'h0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_write_data;
  assign mem_memread    = r_mem_memread;
  assign mem_memwrite   = r_mem_memwrite;
  assign mem_sign_mask  = r_mem_sign_mask;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Testbench for data_mem_initiator: behavioural data memory with a
// configurable write stall, directed cases and a random request loop.
module tb_data_mem_initiator;
  import dmem_pkg::*;

  localparam int STALL_TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr   = 32'h0;
  logic [31:0] req_wdata  = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_clk_stall = 1'b0;
  logic [2:0]  dbg_state;

  data_mem_initiator #(.STALL_TIMEOUT(STALL_TIMEOUT), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] ref_mem[256];
  logic [31:0] mem_arr[256];
  logic        mem_init_done = 1'b0;
  int          stall_len  = 1;
  int          stall_left = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  seen_sm   = 4'h0;
  logic [31:0] seen_addr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    if (i == 32'h40) return 32'h0000_0080;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F00;
  endfunction

  function automatic logic [3:0] exp_sm(input logic w, input logic [2:0] f3);
    case (f3)
      3'b000:  return w ? 4'b0001 : 4'b1001;
      3'b001:  return w ? 4'b0011 : 4'b1011;
      3'b010:  return 4'b0111;
      3'b100:  return w ? 4'b0000 : 4'b0001;
      3'b101:  return w ? 4'b0000 : 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sm, input logic [1:0] a);
    logic [3:0]  be;
    logic [31:0] sh;
    logic [31:0] res;
    case (sm[2:0])
      3'b001:  be = 4'b0001 << a;
      3'b011:  be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    sh  = wd << {a, 3'b000};
    res = old;
    for (int i = 0; i < 4; i++) if (be[i]) res[i*8 +: 8] = sh[i*8 +: 8];
    return res;
  endfunction

  // ---------------- behavioural data memory ----------------
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else begin
      if (mem_memread) mem_read_data <= mem_arr[mem_addr[9:2]];
      if (mem_memwrite) begin
        mem_arr[mem_addr[9:2]] <= merge(mem_arr[mem_addr[9:2]], mem_write_data,
                                        mem_sign_mask, mem_addr[1:0]);
        stall_left    <= stall_len;
        mem_clk_stall <= (stall_len > 0);
      end else if (stall_left > 0) begin
        stall_left    <= stall_left - 1;
        mem_clk_stall <= (stall_left > 1);
      end
    end
  end

  // strobe monitor: counts strobe cycles and records what was presented
  always @(negedge clk) begin
    if (mem_memread)  rd_cnt <= rd_cnt + 1;
    if (mem_memwrite) wr_cnt <= wr_cnt + 1;
    if (mem_memread || mem_memwrite) begin
      seen_sm   <= mem_sign_mask;
      seen_addr <= mem_addr;
    end
  end

  // ---------------- driver ----------------
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int s_len);
    logic        legal, mis, err, got;
    logic [31:0] data;
    logic [3:0]  sm;
    logic [32:0] e;
    int          lat, exp_lat, rd0, wr0, g;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = legal && ((f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'b00));
    err   = !legal || mis;
    sm    = exp_sm(w, f3);
    if (err)              exp_lat = 2;
    else if (!w)          exp_lat = 3;
    else if (s_len == 0)  exp_lat = STALL_TIMEOUT + 3;
    else                  exp_lat = 3 + s_len;
    data = (err || w) ? 32'h0 : ref_mem[addr[9:2]];
    if (w && !err && s_len == 0) err = 1'b1;
    if (w && legal && !mis) ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, sm, addr[1:0]);
    exp_q.push_back({err, data});
    stall_len = s_len;

    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("ready_idle", req_ready, 1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (lat < 40) begin
      if (dbg_state == ST_WRITE_WAIT) begin
        chk("ww_addr", mem_addr, addr);
        chk("ww_wdata", mem_write_data, wdata);
        chk("ww_sm", mem_sign_mask, sm);
      end
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      chk("ready_busy", req_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", got, 1);
    e = exp_q.pop_front();
    if (got) begin
      chk("resp_err", resp_err, e[32]);
      chk("resp_rdata", resp_rdata, e[31:0]);
      chk("latency", lat, exp_lat);
      chk("ready_at_resp", req_ready, 0);
      @(negedge clk);
      chk("ready_after", req_ready, 1);
      chk("rdata_hold", resp_rdata, e[31:0]);
      chk("resp_pulse", resp_valid, 0);
    end
    chk("rd_strobes", rd_cnt - rd0, (!w && legal && !mis) ? 1 : 0);
    chk("wr_strobes", wr_cnt - wr0, (w && legal && !mis) ? 1 : 0);
    if (legal && !mis) begin
      chk("mem_sm", seen_sm, sm);
      chk("mem_addr", seen_addr, addr);
    end
  endtask

  // abandon a store by asserting reset mid-cycle, n_wait cycles after ACCESS
  task automatic reset_mid(input int n_wait, input logic [31:0] addr);
    stall_len = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = addr;
    req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (n_wait == 0) chk("pre_rst_wr", mem_memwrite, 1);
    else begin
      ref_mem[addr[9:2]] = 32'hCAFE_F00D;
      repeat (n_wait) @(negedge clk);
      chk("pre_rst_ww", dbg_state, ST_WRITE_WAIT);
    end
    #2 reset = 1'b1;
    #1;
    chk("rst_wr", mem_memwrite, 0);
    chk("rst_rd", mem_memread, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_resp_after_rst", resp_valid, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_memread", mem_memread, 0);
    chk("rst_memwrite", mem_memwrite, 0);
    chk("rst_sign_mask", mem_sign_mask, 0);
    reset = 1'b0;
    @(negedge clk);

    run_req(1'b0, F3_B, 32'h0000_0103, 32'h0, 1);          // LB -> 0x80
    run_req(1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF, 1);  // SW, 1-cycle stall
    run_req(1'b0, F3_W, 32'h0000_0010, 32'h0, 1);          // read back
    chk("readback_dead", resp_rdata, 32'hDEAD_BEEF);
    run_req(1'b0, F3_H, 32'h0000_0011, 32'h0, 1);          // misaligned LH
    run_req(1'b1, 3'b011, 32'h0000_0020, 32'h1, 1);        // illegal store
    run_req(1'b0, F3_W, 32'h0000_0002, 32'h0, 1);          // misaligned LW
    run_req(1'b1, F3_W, 32'h0000_0040, 32'h1234_5678, 0);  // stall timeout
    run_req(1'b1, F3_W, 32'h0000_2000, 32'h0000_00A5, 2);  // LED address
    run_req(1'b0, F3_W, 32'h0000_2000, 32'h0, 1);
    reset_mid(3, 32'h0000_01F0);                           // reset in WRITE_WAIT
    run_req(1'b0, F3_W, 32'h0000_0020, 32'h0, 1);          // LW 0x20 after reset
    reset_mid(0, 32'h0000_01F4);                           // reset in ACCESS
    run_req(1'b0, F3_W, 32'h0000_01F0, 32'h0, 1);

    for (int k = 0; k < 30; k++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'($urandom_range(0, 32'h1BF)), $urandom, $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
